// File: rtl/tds_channel_readout_arbiter.sv
`timescale 1ns/1ps
// Round-robin readout of the four sTGC TDS channel FIFOs: each 120-bit word is
// tagged with header and channel number and streamed as four 32-bit beats.
module tds_channel_readout_arbiter #(
  parameter int         BURST_MAX = 16,
  parameter logic [3:0] HDR_TAG   = 4'hA
) (
  input  logic         clk160,
  input  logic         reset_n,
  input  logic         run,
  input  logic         flush,
  input  logic [3:0]   ch_enable,
  input  logic [3:0]   channel_fifo_empty,
  input  logic [119:0] channel_data_0,
  input  logic [119:0] channel_data_1,
  input  logic [119:0] channel_data_2,
  input  logic [119:0] channel_data_3,
  output logic [3:0]   channel_data_read,
  output logic [3:0]   data_tran_stop,
  output logic [3:0]   channel_fifo_s_reset,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [31:0]  packet_count,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(BURST_MAX);

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    p_q, p_d;
  logic [7:0]    burst_q, burst_d;
  logic [1:0]    beat_q, beat_d;
  logic [1:0]    flush_cnt_q, flush_cnt_d;
  logic          flush_pend_q, flush_pend_d;
  logic [95:0]   sr_q, sr_d;
  logic [3:0]    read_q, read_d;
  logic [3:0]    stop_q, stop_d;
  logic [3:0]    s_reset_q, s_reset_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   pkt_cnt_q, pkt_cnt_d;
  logic          busy_q, busy_d;

  logic [3:0]    cand;
  logic          found;
  logic [1:0]    pick;
  logic [119:0]  data_sel;
  logic [127:0]  load_word;

  // Scan from the round-robin pointer; descending loop so the nearest candidate wins.
  always_comb begin
    cand  = ch_enable & ~channel_fifo_empty;
    found = 1'b0;
    pick  = p_q;
    for (int k = 3; k >= 0; k--) begin
      if (cand[p_q + 2'(k)]) begin
        found = 1'b1;
        pick  = p_q + 2'(k);
      end
    end
  end

  always_comb begin
    case (grant_q)
      2'd0:    data_sel = channel_data_0;
      2'd1:    data_sel = channel_data_1;
      2'd2:    data_sel = channel_data_2;
      default: data_sel = channel_data_3;
    endcase
    load_word = {HDR_TAG, 2'b00, grant_q, data_sel};
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    p_d          = p_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    flush_cnt_d  = flush_cnt_q;
    sr_d         = sr_q;
    read_d       = 4'b0000;
    s_reset_d    = 4'b0000;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    pkt_cnt_d    = pkt_cnt_q;
    // A flush seen while already flushing is absorbed rather than queued again.
    flush_pend_d = flush_pend_q | (flush & (state_q != S_FLUSH));

    case (state_q)
      S_IDLE: begin
        if (flush_pend_q) begin
          state_d      = S_FLUSH;
          flush_cnt_d  = 2'd0;
          s_reset_d    = 4'hF;
          pkt_cnt_d    = 32'd0;
          burst_d      = 8'd0;
          p_d          = 2'd0;
          flush_pend_d = 1'b0;
        end else if (run && found) begin
          state_d = S_READ;
          grant_d = pick;
          read_d  = 4'b0001 << pick;
          burst_d = burst_q + 8'd1;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        sr_d        = load_word[95:0];
        out_data_d  = load_word[127:96];
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        beat_d      = 2'd0;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          if (beat_q == 2'd3) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            pkt_cnt_d   = pkt_cnt_q + 32'd1;
            if ((burst_q < BURST_LIMIT) && run && ch_enable[grant_q] &&
                !channel_fifo_empty[grant_q]) begin
              state_d = S_READ;
              read_d  = 4'b0001 << grant_q;
              burst_d = burst_q + 8'd1;
            end else begin
              p_d     = grant_q + 2'd1;
              burst_d = 8'd0;
              state_d = S_IDLE;
            end
          end else begin
            beat_d     = beat_q + 2'd1;
            out_last_d = (beat_q == 2'd2);
            case (beat_q)
              2'd0:    out_data_d = sr_q[95:64];
              2'd1:    out_data_d = sr_q[63:32];
              default: out_data_d = sr_q[31:0];
            endcase
          end
        end
      end
      S_FLUSH: begin
        s_reset_d    = 4'hF;
        flush_pend_d = 1'b0;
        if (flush_cnt_q == 2'd3) begin
          s_reset_d = 4'h0;
          state_d   = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered from next state so the stop lines cover the whole flush window.
    stop_d = ~({4{run}} & ch_enable) | {4{state_d == S_FLUSH}};
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the payload register is reset too so out_data is defined.
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      p_q          <= 2'd0;
      burst_q      <= 8'd0;
      beat_q       <= 2'd0;
      flush_cnt_q  <= 2'd0;
      flush_pend_q <= 1'b0;
      sr_q         <= '0;
      read_q       <= 4'b0000;
      stop_q       <= 4'hF;
      s_reset_q    <= 4'b0000;
      out_data_q   <= 32'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      pkt_cnt_q    <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      p_q          <= p_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      sr_q         <= sr_d;
      read_q       <= read_d;
      stop_q       <= stop_d;
      s_reset_q    <= s_reset_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      pkt_cnt_q    <= pkt_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign channel_data_read    = read_q;
  assign data_tran_stop       = stop_q;
  assign channel_fifo_s_reset = s_reset_q;
  assign out_data             = out_data_q;
  assign out_valid            = out_valid_q;
  assign out_last             = out_last_q;
  assign packet_count         = pkt_cnt_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_tds_channel_readout_arbiter.sv
`timescale 1ns/1ps
// Directed bench for tds_channel_readout_arbiter: FIFO models per channel, a
// beat/read monitor, and one task per scenario with hand-derived expectations.
module tb_tds_channel_readout_arbiter;

  localparam logic [3:0] TAG = 4'hA;

  logic         clk160 = 1'b0;
  logic         reset_n = 1'b0;
  logic         run = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   ch_enable = 4'hF;
  logic [3:0]   channel_fifo_empty = 4'hF;
  logic [119:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]   channel_data_read;
  logic [3:0]   data_tran_stop;
  logic [3:0]   channel_fifo_s_reset;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic [31:0]  packet_count;
  logic         busy;

  int passed = 0;
  int total  = 0;

  tds_channel_readout_arbiter #(.BURST_MAX(16), .HDR_TAG(4'hA)) dut (
    .clk160               (clk160),
    .reset_n              (reset_n),
    .run                  (run),
    .flush                (flush),
    .ch_enable            (ch_enable),
    .channel_fifo_empty   (channel_fifo_empty),
    .channel_data_0       (d0),
    .channel_data_1       (d1),
    .channel_data_2       (d2),
    .channel_data_3       (d3),
    .channel_data_read    (channel_data_read),
    .data_tran_stop       (data_tran_stop),
    .channel_fifo_s_reset (channel_fifo_s_reset),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_last             (out_last),
    .packet_count         (packet_count),
    .busy                 (busy)
  );

  always #5 clk160 = ~clk160;

  // ---------------- channel FIFO models ----------------
  logic [119:0] fq0[$], fq1[$], fq2[$], fq3[$];

  always @(posedge clk160) begin
    logic [119:0] n0, n1, n2, n3;
    n0 = d0; n1 = d1; n2 = d2; n3 = d3;
    if (channel_data_read[0] && fq0.size() > 0) n0 = fq0.pop_front();
    if (channel_data_read[1] && fq1.size() > 0) n1 = fq1.pop_front();
    if (channel_data_read[2] && fq2.size() > 0) n2 = fq2.pop_front();
    if (channel_data_read[3] && fq3.size() > 0) n3 = fq3.pop_front();
    #1;
    d0 = n0; d1 = n1; d2 = n2; d3 = n3;
    channel_fifo_empty = {fq3.size() == 0, fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
  end

  task automatic push_word(input int c, input logic [119:0] w);
    case (c)
      0:       fq0.push_back(w);
      1:       fq1.push_back(w);
      2:       fq2.push_back(w);
      default: fq3.push_back(w);
    endcase
  endtask

  function automatic logic [119:0] mk(input int c, input int n);
    mk = {8'(c), 16'(n), 96'h0123_4567_89AB_CDEF_0000_0ABC};
  endfunction

  function automatic logic [127:0] expk(input int c, input logic [119:0] w);
    expk = {TAG, 2'b00, 2'(c), w};
  endfunction

  // ---------------- monitor ----------------
  typedef struct {
    logic [127:0] data;
    logic [3:0]   lastm;
    int           c0;
    int           c3;
  } pkt_t;
  typedef struct {
    int         cyc;
    logic [3:0] rd;
  } rd_t;

  pkt_t pkts[$];
  rd_t  rds[$];
  int   cyc = 0;
  int   mbeat = 0;
  int   mc0 = 0;
  logic [127:0] macc = '0;
  logic [3:0]   mlast = '0;

  always @(posedge clk160) cyc++;

  always @(negedge clk160) begin
    if (!reset_n) begin
      mbeat = 0;
    end else begin
      if (channel_data_read != 4'b0000) begin
        rd_t r;
        r.cyc = cyc;
        r.rd  = channel_data_read;
        rds.push_back(r);
      end
      if (out_valid && out_ready) begin
        macc  = {macc[95:0], out_data};
        mlast = {mlast[2:0], out_last};
        if (mbeat == 0) mc0 = cyc;
        if (mbeat == 3) begin
          pkt_t p;
          p.data  = macc;
          p.lastm = mlast;
          p.c0    = mc0;
          p.c3    = cyc;
          pkts.push_back(p);
          mbeat = 0;
        end else begin
          mbeat++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    reset_n   = 1'b0;
    run       = 1'b0;
    flush     = 1'b0;
    ch_enable = 4'hF;
    out_ready = 1'b1;
    fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
    repeat (3) @(posedge clk160);
    @(negedge clk160);
    reset_n = 1'b1;
    pkts.delete();
    rds.delete();
  endtask

  task automatic wait_pkts(input int n, input int budget, input string name);
    int k = 0;
    while (pkts.size() < n && k < budget) begin
      @(posedge clk160);
      k++;
    end
    total++;
    if (pkts.size() < n)
      $display("FAIL %s_timeout: got %0d packets, required %0d", name, pkts.size(), n);
    else passed++;
  endtask

  task automatic check_reset_values(input string name);
    total++; if (channel_data_read !== 4'h0) $display("FAIL %s_read: got %h required 0", name, channel_data_read); else passed++;
    total++; if (channel_fifo_s_reset !== 4'h0) $display("FAIL %s_s_reset: got %h required 0", name, channel_fifo_s_reset); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL %s_valid: got %b required 0", name, out_valid); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL %s_last: got %b required 0", name, out_last); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL %s_data: got %h required 0", name, out_data); else passed++;
    total++; if (data_tran_stop !== 4'hF) $display("FAIL %s_stop: got %h required f", name, data_tran_stop); else passed++;
    total++; if (packet_count !== 32'd0) $display("FAIL %s_pcount: got %0d required 0", name, packet_count); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s_busy: got %b required 0", name, busy); else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk160);
    @(negedge clk160);
    check_reset_values("reset");
    do_reset();
    repeat (3) @(negedge clk160);
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b required 0", busy); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    push_word(2, mk(2, 0));
    run = 1'b1;
    wait_pkts(1, 100, "single");
    @(negedge clk160);
    total++; if (rds.size() != 1) $display("FAIL single_nreads: got %0d required 1", rds.size()); else passed++;
    if (rds.size() > 0 && pkts.size() > 0) begin
      total++; if (rds[0].rd !== 4'b0100) $display("FAIL single_read_ch: got %b required 0100", rds[0].rd); else passed++;
      total++; if (pkts[0].data !== expk(2, mk(2, 0))) $display("FAIL single_data: got %h required %h", pkts[0].data, expk(2, mk(2, 0))); else passed++;
      total++; if (pkts[0].data[127:120] !== 8'hA2) $display("FAIL single_hdr: got %h required a2", pkts[0].data[127:120]); else passed++;
      total++; if (pkts[0].data[11:0] !== 12'hABC) $display("FAIL single_tail: got %h required abc", pkts[0].data[11:0]); else passed++;
      total++; if (pkts[0].lastm !== 4'b0001) $display("FAIL single_last: got %b required 0001", pkts[0].lastm); else passed++;
      total++; if (pkts[0].c0 - rds[0].cyc != 2) $display("FAIL single_lat_valid: got %0d required 2", pkts[0].c0 - rds[0].cyc); else passed++;
      total++; if (pkts[0].c3 - rds[0].cyc != 5) $display("FAIL single_lat_last: got %0d required 5", pkts[0].c3 - rds[0].cyc); else passed++;
    end
    total++; if (packet_count !== 32'd1) $display("FAIL single_pcount: got %0d required 1", packet_count); else passed++;
    repeat (3) @(negedge clk160);
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b required 0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    int idx[4];
    int k;
    int burst_len[2];
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idx[c] = 0;
      for (int n = 0; n < 20; n++) push_word(c, mk(c, n));
    end
    burst_len[0] = 16;
    burst_len[1] = 4;
    run = 1'b1;
    wait_pkts(80, 1500, "rr");
    @(negedge clk160);
    total++; if (rds.size() != 80) $display("FAIL rr_nreads: got %0d required 80", rds.size()); else passed++;
    k = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < burst_len[r]; j++) begin
          if (k < rds.size() && k < pkts.size()) begin
            total++; if (rds[k].rd !== 4'(1 << c)) $display("FAIL rr_order[%0d]: got %b required ch%0d", k, rds[k].rd, c); else passed++;
            total++; if (pkts[k].data !== expk(c, mk(c, idx[c]))) $display("FAIL rr_data[%0d]: got %h required %h", k, pkts[k].data, expk(c, mk(c, idx[c]))); else passed++;
          end
          idx[c]++;
          k++;
        end
      end
    end
    if (rds.size() >= 17) begin
      total++; if (rds[1].cyc - rds[0].cyc != 6) $display("FAIL rr_burst_spacing: got %0d required 6", rds[1].cyc - rds[0].cyc); else passed++;
      total++; if (rds[16].cyc - rds[15].cyc != 7) $display("FAIL rr_switch_spacing: got %0d required 7", rds[16].cyc - rds[15].cyc); else passed++;
    end
    total++; if (packet_count !== 32'd80) $display("FAIL rr_pcount: got %0d required 80", packet_count); else passed++;
  endtask

  task automatic test_stall();
    int k = 0;
    int viol = 0;
    int rdviol = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [31:0] prev_d = '0;
    do_reset();
    push_word(1, mk(1, 0));
    push_word(1, mk(1, 1));
    out_ready = 1'b0;
    run = 1'b1;
    while (pkts.size() < 2 && k < 300) begin
      @(posedge clk160);
      #1 out_ready = (k % 3 == 0);
      @(negedge clk160);
      if (prev_v && !prev_r && (!out_valid || out_data !== prev_d || out_last !== prev_l)) viol++;
      if (channel_data_read != 4'b0000 && out_valid) rdviol++;
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_l = out_last;
      k++;
    end
    total++; if (pkts.size() < 2) $display("FAIL stall_timeout: got %0d packets required 2", pkts.size()); else passed++;
    total++; if (viol != 0) $display("FAIL stall_stable: got %0d changes while stalled, required 0", viol); else passed++;
    total++; if (rdviol != 0) $display("FAIL stall_early_read: got %0d reads during packet, required 0", rdviol); else passed++;
    for (int i = 0; i < 2; i++) begin
      if (i < pkts.size()) begin
        total++; if (pkts[i].data !== expk(1, mk(1, i))) $display("FAIL stall_data[%0d]: got %h required %h", i, pkts[i].data, expk(1, mk(1, i))); else passed++;
        total++; if (pkts[i].lastm !== 4'b0001) $display("FAIL stall_last[%0d]: got %b required 0001", i, pkts[i].lastm); else passed++;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_flush();
    int k = 0;
    int nf = 0;
    int bad = 0;
    do_reset();
    push_word(3, mk(3, 0));
    run = 1'b1;
    while (!out_valid && k < 50) begin
      @(negedge clk160);
      k++;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL flush_no_valid: got %b required 1", out_valid); else passed++;
    @(posedge clk160);
    #1 flush = 1'b1;
    @(posedge clk160);
    #1 flush = 1'b0;
    wait_pkts(1, 50, "flush_pkt");
    if (pkts.size() > 0) begin
      total++; if (pkts[0].data !== expk(3, mk(3, 0))) $display("FAIL flush_pkt_data: got %h required %h", pkts[0].data, expk(3, mk(3, 0))); else passed++;
    end
    @(negedge clk160);
    total++; if (packet_count !== 32'd1) $display("FAIL flush_pcount_before: got %0d required 1", packet_count); else passed++;
    total++; if (channel_fifo_s_reset !== 4'h0) $display("FAIL flush_early: got %h required 0", channel_fifo_s_reset); else passed++;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk160);
      flush = 1'b0;
      if (channel_fifo_s_reset === 4'hF) begin
        nf++;
        if (!busy || data_tran_stop !== 4'hF) bad++;
        if (nf == 1) begin
          total++; if (packet_count !== 32'd0) $display("FAIL flush_pcount_clear: got %0d required 0", packet_count); else passed++;
        end
        if (nf == 2) flush = 1'b1;
      end else if (channel_fifo_s_reset !== 4'h0) begin
        bad++;
      end
    end
    total++; if (nf != 4) $display("FAIL flush_window: got %0d cycles required 4", nf); else passed++;
    total++; if (bad != 0) $display("FAIL flush_busy_stop: got %0d bad cycles required 0", bad); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL flush_busy_end: got %b required 0", busy); else passed++;
  endtask

  task automatic test_enable_mask();
    int n2 = 0;
    do_reset();
    ch_enable = 4'b1011;
    push_word(2, mk(2, 0));
    push_word(2, mk(2, 1));
    push_word(0, mk(0, 0));
    run = 1'b1;
    repeat (40) @(posedge clk160);
    @(negedge clk160);
    foreach (rds[i]) if (rds[i].rd[2]) n2++;
    total++; if (n2 != 0) $display("FAIL mask_ch2_read: got %0d reads required 0", n2); else passed++;
    total++; if (rds.size() != 1) $display("FAIL mask_nreads: got %0d required 1", rds.size()); else passed++;
    total++; if (pkts.size() != 1) $display("FAIL mask_npkts: got %0d required 1", pkts.size()); else passed++;
    total++; if (data_tran_stop !== 4'b0100) $display("FAIL mask_stop_run: got %b required 0100", data_tran_stop); else passed++;
    @(posedge clk160);
    #1 run = 1'b0;
    @(posedge clk160);
    @(negedge clk160);
    total++; if (data_tran_stop !== 4'hF) $display("FAIL mask_stop_norun: got %h required f", data_tran_stop); else passed++;
  endtask

  task automatic test_async_reset();
    int k = 0;
    do_reset();
    push_word(1, mk(1, 0));
    run = 1'b1;
    wait_pkts(1, 60, "areset_pre");
    push_word(2, mk(2, 0));
    while (!out_valid && k < 50) begin
      @(negedge clk160);
      k++;
    end
    total++; if (out_valid !== 1'b1) $display("FAIL areset_no_send: got %b required 1", out_valid); else passed++;
    #1 reset_n = 1'b0;
    #1 check_reset_values("areset");
    fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
    push_word(0, mk(0, 7));
    push_word(3, mk(3, 7));
    repeat (2) @(posedge clk160);
    @(negedge clk160);
    reset_n = 1'b1;
    rds.delete();
    pkts.delete();
    k = 0;
    while (rds.size() == 0 && k < 30) begin
      @(negedge clk160);
      k++;
    end
    total++; if (rds.size() == 0) $display("FAIL areset_no_grant: got no read required ch0"); else passed++;
    if (rds.size() > 0) begin
      total++; if (rds[0].rd !== 4'b0001) $display("FAIL areset_first_grant: got %b required 0001", rds[0].rd); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_flush();
    test_enable_mask();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
